// File: rtl/washer_pkg.sv
// Shared state encodings and widths for the washer controller.
package washer_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WASH  = 3'd2,
    S_RINSE = 3'd3,
    S_SPIN  = 3'd4,
    S_DONE  = 3'd5,
    S_FAULT = 3'd6
  } state_e;

endpackage

// File: rtl/washer_ctrl_multi_if.sv
// Host-side bundle of the washer controller: commands in, status out.
interface washer_ctrl_multi_if
  import washer_pkg::*;
#(
  parameter int REP_W = 3
);

  logic               coin_insert;
  logic [REP_W-1:0]   wash_reps;
  logic               lid;
  logic               abort;
  logic [STATE_W-1:0] state_o;
  logic [REP_W-1:0]   rep_o;
  logic               busy;
  logic               lid_paused;
  logic               laundry_done;
  logic               fault;

  modport master (
    output coin_insert, wash_reps, lid, abort,
    input  state_o, rep_o, busy,
    input  lid_paused, laundry_done, fault
  );

  modport slave (
    input  coin_insert, wash_reps, lid, abort,
    output state_o, rep_o, busy,
    output lid_paused, laundry_done, fault
  );

endinterface

// File: rtl/washer_phase_timer.sv
// Phase timer: clear / hold / increment with terminal-count compare.
module washer_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] len_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tc_o = (cnt_q == len_i - CNT_W'(1));

endmodule

// File: rtl/washer_ctrl_multi.sv
// Multi-rinse washer sequencer FILL/WASH/RINSE x reps, then SPIN.
// Define LID_TIMEOUT_EN to fault on an over-long lid pause.
module washer_ctrl_multi
  import washer_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int FILL_CYC  = 10,
  parameter int WASH_CYC  = 10,
  parameter int RINSE_CYC = 10,
  parameter int SPIN_CYC  = 10,
  parameter int MAX_REPS  = 4,
  parameter int LID_TMO   = 50
) (
  input logic          clk,
  input logic          rst,
  washer_ctrl_multi_if.slave bus
);

  localparam int REP_W = $clog2(MAX_REPS + 1);
  localparam logic [REP_W-1:0] MAXR = REP_W'(MAX_REPS);

  state_e           state_q, state_d;
  logic [REP_W-1:0] reps_q, reps_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [CNT_W-1:0] len;
  logic             tc, active, paused, to;
  logic             clr, inc;

  assign active = (state_q == S_FILL) || (state_q == S_WASH) ||
                  (state_q == S_RINSE) || (state_q == S_SPIN);
  assign paused = active && bus.lid;

`ifdef LID_TIMEOUT_EN
  localparam int PW = $clog2(LID_TMO + 1);
  logic [PW-1:0] pause_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pause_q <= '0;
    end else if (paused && !bus.abort) begin
      pause_q <= pause_q + PW'(1);
    end else begin
      pause_q <= '0;
    end
  end

  assign to = paused && (pause_q == PW'(LID_TMO - 1));
`else
  assign to = 1'b0;
`endif

  always_comb begin
    len = CNT_W'(FILL_CYC);
    unique case (state_q)
      S_WASH:  len = CNT_W'(WASH_CYC);
      S_RINSE: len = CNT_W'(RINSE_CYC);
      S_SPIN:  len = CNT_W'(SPIN_CYC);
      default: len = CNT_W'(FILL_CYC);
    endcase
  end

  // Any state change restarts the timer; idle states keep it at zero.
  assign clr = (state_d != state_q) || !active;
  assign inc = active && !bus.lid;

  washer_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (clr),
    .inc_i (inc),
    .len_i (len),
    .tc_o  (tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      reps_q  <= '0;
      rep_q   <= '0;
    end else begin
      state_q <= state_d;
      reps_q  <= reps_d;
      rep_q   <= rep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    reps_d  = reps_q;
    rep_d   = rep_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.coin_insert && !bus.lid) begin
          state_d = S_FILL;
          rep_d   = REP_W'(1);
          if (bus.wash_reps == '0) begin
            reps_d = REP_W'(1);
          end else if (bus.wash_reps > MAXR) begin
            reps_d = MAXR;
          end else begin
            reps_d = bus.wash_reps;
          end
        end
      end
      S_FILL, S_WASH, S_RINSE, S_SPIN: begin
        // Abort beats lid, lid beats terminal count.
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (to) begin
          state_d = S_FAULT;
        end else if (!bus.lid && tc) begin
          unique case (1'b1)
            state_q == S_FILL: state_d = S_WASH;
            state_q == S_WASH: state_d = S_RINSE;
            state_q == S_SPIN: state_d = S_DONE;
            default: begin
              if (rep_q < reps_q) begin
                state_d = S_FILL;
                rep_d   = rep_q + REP_W'(1);
              end else begin
                state_d = S_SPIN;
              end
            end
          endcase
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: if (bus.abort) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE) begin
      rep_d  = '0;
      reps_d = '0;
    end
  end

  always_comb begin
    bus.state_o      = state_q;
    bus.rep_o        = rep_q;
    bus.busy         = active;
    bus.lid_paused   = paused;
    bus.laundry_done = (state_q == S_DONE);
`ifdef LID_TIMEOUT_EN
    bus.fault        = (state_q == S_FAULT);
`else
    bus.fault        = 1'b0;
`endif
  end

endmodule

// File: tb/tb_washer_ctrl_multi.sv
// Directed bench for washer_ctrl_multi, all phases 10 cycles.
module tb_washer_ctrl_multi;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  washer_ctrl_multi_if #(.REP_W(3)) bus ();

  washer_ctrl_multi #(
    .CNT_W     (8),
    .FILL_CYC  (10),
    .WASH_CYC  (10),
    .RINSE_CYC (10),
    .SPIN_CYC  (10),
    .MAX_REPS  (4),
    .LID_TMO   (20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start(logic [2:0] reps);
    bus.coin_insert = 1'b1;
    bus.wash_reps   = reps;
    tick();
    bus.coin_insert = 1'b0;
    bus.wash_reps   = 3'd2;
  endtask

  // Cycles from now until laundry_done is seen, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (n < 400) begin
      tick();
      n++;
      if (bus.laundry_done) break;
    end
  endtask

  task automatic watch_no_done(string tag, int cyc);
    int seen;
    seen = 0;
    for (int i = 0; i < cyc; i++) begin
      tick();
      if (bus.laundry_done) seen++;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    int n;
    bus.coin_insert = 1'b0;
    bus.wash_reps   = 3'd0;
    bus.lid         = 1'b0;
    bus.abort       = 1'b0;
    tick(2);
    chk("rst_state", bus.state_o, 0);
    chk("rst_rep", bus.rep_o, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.laundry_done, 0);
    chk("rst_fault", bus.fault, 0);
    rst = 1'b1;
    tick();
    chk("idle_hold", bus.state_o, 0);

    start(3'd1);
    chk("fill_entry", bus.state_o, 1);
    chk("fill_rep", bus.rep_o, 1);
    chk("fill_busy", bus.busy, 1);
    bus.coin_insert = 1'b1;
    wait_done(n);
    bus.coin_insert = 1'b0;
    chk("lat_r1", n, 40);
    chk("done_state", bus.state_o, 5);
    tick();
    chk("done_pulse", bus.laundry_done, 0);
    chk("done_idle", bus.state_o, 0);

    start(3'd2);
    tick(29);
    chk("r2_rinse1", bus.state_o, 3);
    chk("r2_rep1", bus.rep_o, 1);
    tick();
    chk("r2_fill2", bus.state_o, 1);
    chk("r2_rep2", bus.rep_o, 2);
    wait_done(n);
    chk("lat_r2", 30 + n, 70);
    tick();

    start(3'd0);
    wait_done(n);
    chk("lat_r0", n, 40);
    tick();

    start(3'd7);
    wait_done(n);
    chk("lat_r7", n, 130);
    tick();

    start(3'd1);
    tick(15);
    bus.lid = 1'b1;
    #1;
    chk("pause_flag", bus.lid_paused, 1);
    tick(5);
    chk("pause_state", bus.state_o, 2);
    bus.lid = 1'b0;
    #1;
    chk("pause_clear", bus.lid_paused, 0);
    wait_done(n);
    chk("lat_pause", 20 + n, 45);
    tick();

    bus.lid = 1'b1;
    bus.coin_insert = 1'b1;
    tick();
    chk("lid_coin", bus.state_o, 0);
    bus.lid = 1'b0;
    bus.coin_insert = 1'b0;

    start(3'd1);
    tick(23);
    chk("rinse_c3", bus.state_o, 3);
    bus.abort = 1'b1;
    bus.lid   = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.lid   = 1'b0;
    chk("abort_idle", bus.state_o, 0);
    chk("abort_rep", bus.rep_o, 0);
    watch_no_done("abort_nodone", 60);

    start(3'd1);
    tick(35);
    chk("spin_mid", bus.state_o, 4);
    rst = 1'b0;
    #1;
    chk("arst_state", bus.state_o, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_rep", bus.rep_o, 0);
    tick();
    rst = 1'b1;
    watch_no_done("arst_nodone", 60);

    start(3'd1);
    bus.lid = 1'b1;
`ifdef LID_TIMEOUT_EN
    tick(19);
    chk("tmo_pre", bus.state_o, 1);
    tick();
    chk("tmo_state", bus.state_o, 6);
    chk("tmo_fault", bus.fault, 1);
    chk("tmo_busy", bus.busy, 0);
    bus.lid = 1'b0;
    tick(3);
    chk("fault_hold", bus.state_o, 6);
`else
    tick(100);
    chk("notmo_state", bus.state_o, 1);
    chk("notmo_fault", bus.fault, 0);
    chk("notmo_paused", bus.lid_paused, 1);
    bus.lid = 1'b0;
`endif
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("end_idle", bus.state_o, 0);
    chk("end_fault", bus.fault, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
